// File: rtl/decim_reconfig_ctrl_if.sv
// decim_reconfig_ctrl_if: host config handshake plus upstream/downstream sample gating signals
interface decim_reconfig_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_cic_dec;
    logic [7:0] cfg_fir_dec;
    logic       cfg_bypass_cic;
    logic       cfg_bypass_fir;
    logic       cfg_run;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;

    modport master (
        output cfg_valid, cfg_cic_dec, cfg_fir_dec, cfg_bypass_cic, cfg_bypass_fir, cfg_run, in_valid,
        input  cfg_ready, in_ready, out_valid
    );

    modport slave (
        input  cfg_valid, cfg_cic_dec, cfg_fir_dec, cfg_bypass_cic, cfg_bypass_fir, cfg_run, in_valid,
        output cfg_ready, in_ready, out_valid
    );
endinterface

// File: rtl/decim_reconfig_ctrl.sv
// decim_reconfig_ctrl: sequences the decimation chain through drain, flush and settle on every
// start/stop/ratio change so no sample built from mixed configurations reaches downstream.
module decim_reconfig_ctrl #(
    parameter int DEFAULT_CIC    = 8,
    parameter int DEFAULT_FIR    = 4,
    parameter int DRAIN_CYCLES   = 16,
    parameter int FLUSH_CYCLES   = 4,
    parameter int SETTLE_SAMPLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    decim_reconfig_ctrl_if.slave  bus,
    output logic                  dec_data_valid,
    input  logic                  dec_data_ready,
    input  logic                  dec_out_valid,
    output logic                  dec_enable,
    output logic                  dec_rst_n,
    output logic [7:0]            cic_decimation,
    output logic [7:0]            fir_decimation,
    output logic                  bypass_cic,
    output logic                  bypass_fir,
    output logic                  locked,
    output logic                  cfg_err,
    output logic [2:0]            state,
    output logic [7:0]            reconfig_count
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int SW = SETTLE_SAMPLES > 0 ? $clog2(SETTLE_SAMPLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        FLUSH  = 3'd2,
        SETTLE = 3'd3,
        RUN    = 3'd4
    } st_t;

    st_t           st, st_n;
    logic [DW-1:0] drain_cnt;
    logic [FW-1:0] flush_cnt;
    logic [SW-1:0] settle_cnt;
    logic          accept, bad, take, ingress;
    logic          drain_done, flush_done, settle_done;
    logic [7:0]    p_cic, p_fir;
    logic          p_bc, p_bf, p_run;

    assign bus.cfg_ready = st == IDLE || st == RUN;
    assign accept        = bus.cfg_valid & bus.cfg_ready;
    assign bad           = (bus.cfg_cic_dec == 8'd0 && !bus.cfg_bypass_cic) ||
                           (bus.cfg_fir_dec == 8'd0 && !bus.cfg_bypass_fir);
    assign take          = accept & ~bad;

    assign drain_done  = int'(drain_cnt) == DRAIN_CYCLES - 1;
    assign flush_done  = int'(flush_cnt) == FLUSH_CYCLES - 1;
    assign settle_done = dec_out_valid && int'(settle_cnt) == SETTLE_SAMPLES - 1;

    // Gating follows the current state so a sample on the acceptance edge still goes through
    assign ingress        = st == RUN || st == SETTLE;
    assign bus.in_ready   = ingress & dec_data_ready;
    assign dec_data_valid = ingress & bus.in_valid & dec_data_ready;
    assign bus.out_valid  = (st == RUN || st == DRAIN) & dec_out_valid;
    assign state          = st;

    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else     st <= st_n;

    always_comb begin
        st_n = st;
        case (st)
            IDLE:    if (take && bus.cfg_run) st_n = FLUSH;
            RUN:     if (take) st_n = DRAIN;
            DRAIN:   if (drain_done) st_n = p_run ? FLUSH : IDLE;
            FLUSH:   if (flush_done) st_n = SETTLE_SAMPLES == 0 ? RUN : SETTLE;
            SETTLE:  if (settle_done) st_n = RUN;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            drain_cnt  <= '0;
            flush_cnt  <= '0;
            settle_cnt <= '0;
        end else if (st_n != st) begin
            drain_cnt  <= '0;
            flush_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            if (st == DRAIN && int'(drain_cnt) < DRAIN_CYCLES) drain_cnt <= drain_cnt + 1'b1;
            if (st == FLUSH && int'(flush_cnt) < FLUSH_CYCLES) flush_cnt <= flush_cnt + 1'b1;
            if (st == SETTLE && dec_out_valid && int'(settle_cnt) < SETTLE_SAMPLES)
                settle_cnt <= settle_cnt + 1'b1;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dec_enable     <= 1'b0;
            dec_rst_n      <= 1'b0;
            locked         <= 1'b0;
            cfg_err        <= 1'b0;
            reconfig_count <= 8'd0;
            cic_decimation <= 8'(DEFAULT_CIC);
            fir_decimation <= 8'(DEFAULT_FIR);
            bypass_cic     <= 1'b0;
            bypass_fir     <= 1'b0;
            p_cic          <= 8'(DEFAULT_CIC);
            p_fir          <= 8'(DEFAULT_FIR);
            p_bc           <= 1'b0;
            p_bf           <= 1'b0;
            p_run          <= 1'b0;
        end else begin
            dec_enable <= st_n == DRAIN || st_n == SETTLE || st_n == RUN;
            dec_rst_n  <= st_n != FLUSH;
            locked     <= st_n == RUN;
            cfg_err    <= accept & bad;
            if (take) begin
                reconfig_count <= reconfig_count + 8'd1;
                {p_cic, p_fir, p_bc, p_bf, p_run} <= {bus.cfg_cic_dec, bus.cfg_fir_dec,
                    bus.cfg_bypass_cic, bus.cfg_bypass_fir, bus.cfg_run};
            end
            // From IDLE the request is applied straight away; after DRAIN it comes from the held copy
            if (st_n == FLUSH && st != FLUSH)
                {cic_decimation, fir_decimation, bypass_cic, bypass_fir} <= st == IDLE ?
                    {bus.cfg_cic_dec, bus.cfg_fir_dec, bus.cfg_bypass_cic, bus.cfg_bypass_fir} :
                    {p_cic, p_fir, p_bc, p_bf};
        end
endmodule
